// File: rtl/main_pkg.sv
// Shared definitions for the operand-registered ALU: state encodings,
// select-bit indices and the default datapath width.
package main_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_ERROR = 2'b11;

    localparam int unsigned IN_PERSIST = 2;
    localparam int unsigned IN_LOAD    = 1;
    localparam int unsigned IN_CLR     = 0;

    localparam int unsigned OP_ADD = 6;
    localparam int unsigned OP_SUB = 5;
    localparam int unsigned OP_MUL = 4;
    localparam int unsigned OP_DIV = 3;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 1;
    localparam int unsigned OP_XOR = 0;

    function automatic logic is_onehot7(input logic [6:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (v[i]) cnt = cnt + 1;
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/main_alu_core.sv
// Combinational ALU: one-hot op select over two unsigned operands, flagging
// a malformed select or a divide by zero.
module alu_core
    import main_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [6:0]       out_sel,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    logic [2*WIDTH-1:0] prod;
    logic               onehot;
    logic               div_zero;

    always_comb begin
        prod     = '0;
        result   = '0;
        onehot   = is_onehot7(out_sel);
        div_zero = out_sel[OP_DIV] && (b == '0);
        err      = !onehot || div_zero;
        if (onehot) begin
            unique case (1'b1)
                out_sel[OP_ADD]: result = a + b;
                out_sel[OP_SUB]: result = a - b;
                out_sel[OP_MUL]: begin
                    prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                    result = prod[WIDTH-1:0];
                end
                // Quotient forced to zero on b==0 so no X leaks; err blocks its use.
                out_sel[OP_DIV]: result = div_zero ? '0 : a / b;
                out_sel[OP_AND]: result = a & b;
                out_sel[OP_OR]:  result = a | b;
                out_sel[OP_XOR]: result = a ^ b;
                default:         result = '0;
            endcase
        end
    end

endmodule

// File: rtl/main.sv
// Operand-registered ALU top: operand registers, run-control FSM and
// registered result around the combinational alu_core.
module main
    import main_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             on,
    input  logic             rst,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] final1,
    output logic [WIDTH-1:0] final2,
    input  logic [6:0]       out_sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] final1_q, final1_d;
    logic [WIDTH-1:0] final2_q, final2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a       (final1_q),
        .b       (final2_q),
        .out_sel (out_sel),
        .result  (alu_result),
        .err     (alu_err)
    );

    always_comb begin
        state_d = state_q;
        if (!on) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_READY;
                ST_READY: state_d = ST_RUN;
                ST_RUN:   state_d = alu_err ? ST_ERROR : ST_RUN;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        final1_d = final1_q;
        final2_d = final2_q;
        if (on) begin
            if (in_sel[IN_CLR]) begin
                final1_d = '0;
                final2_d = '0;
            end else if (in_sel[IN_LOAD]) begin
                final1_d = num1;
                final2_d = num2;
            end else if (in_sel[IN_PERSIST]) begin
                final1_d = final1_q;
                final2_d = final2_q;
            end
        end
    end

    // Result is computed from the pre-edge operands, so a same-cycle load
    // only affects the following result.
    always_comb begin
        out_d = out_q;
        if (on && (state_q == ST_RUN) && !alu_err) begin
            out_d = alu_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            final1_q <= '0;
            final2_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            final1_q <= final1_d;
            final2_q <= final2_d;
            out_q    <= out_d;
        end
    end

    assign final1    = final1_q;
    assign final2    = final2_q;
    assign out       = out_q;
    assign currState = state_q;
    assign nextState = state_d;

endmodule

// File: tb/tb_main.sv
// Directed self-checking bench for the operand-registered ALU.
module tb_main;

    logic       clk;
    logic       on;
    logic       rst;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [7:0] final1;
    logic [7:0] final2;
    logic [6:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState;
    logic [1:0] nextState;

    int total;
    int bad;

    localparam logic [6:0] S_ADD = 7'b1000000;
    localparam logic [6:0] S_SUB = 7'b0100000;
    localparam logic [6:0] S_MUL = 7'b0010000;
    localparam logic [6:0] S_DIV = 7'b0001000;
    localparam logic [6:0] S_AND = 7'b0000100;
    localparam logic [6:0] S_OR  = 7'b0000010;
    localparam logic [6:0] S_XOR = 7'b0000001;

    main #(.WIDTH(8)) dut (
        .clk       (clk),
        .on        (on),
        .rst       (rst),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .final1    (final1),
        .final2    (final2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; on = 1'b0; in_sel = 3'b000; num1 = 8'd0; num2 = 8'd0; out_sel = S_ADD;
        #2;
        total++; if (out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
        total++; if (final1 !== 8'd0) begin bad++; $display("FAIL reset_final1 got=%0d exp=0", final1); end
        total++; if (final2 !== 8'd0) begin bad++; $display("FAIL reset_final2 got=%0d exp=0", final2); end
        total++; if (currState !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", currState); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bringup_add();
        on = 1'b1; in_sel = 3'b010; num1 = 8'd87; num2 = 8'd26; out_sel = S_ADD;
        #1;
        total++; if (nextState !== 2'b01) begin bad++; $display("FAIL bring_next0 got=%b exp=01", nextState); end
        tick();
        total++; if (currState !== 2'b01) begin bad++; $display("FAIL bring_state1 got=%b exp=01", currState); end
        total++; if (final1 !== 8'd87) begin bad++; $display("FAIL bring_final1 got=%0d exp=87", final1); end
        total++; if (final2 !== 8'd26) begin bad++; $display("FAIL bring_final2 got=%0d exp=26", final2); end
        total++; if (out !== 8'd0) begin bad++; $display("FAIL bring_out_ready got=%0d exp=0", out); end
        tick();
        total++; if (currState !== 2'b10) begin bad++; $display("FAIL bring_state2 got=%b exp=10", currState); end
        total++; if (out !== 8'd0) begin bad++; $display("FAIL bring_out_entry got=%0d exp=0", out); end
        tick();
        total++; if (out !== 8'd113) begin bad++; $display("FAIL bring_add got=%0d exp=113", out); end
        total++; if (currState !== 2'b10) begin bad++; $display("FAIL bring_state_run got=%b exp=10", currState); end
    endtask

    task automatic test_op_sweep();
        logic [6:0] sels [6];
        logic [7:0] exps [6];
        sels = '{S_SUB, S_MUL, S_DIV, S_AND, S_OR, S_XOR};
        exps = '{8'd61, 8'd214, 8'd3, 8'h12, 8'h5F, 8'h4D};
        in_sel = 3'b100; num1 = 8'hFF; num2 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            out_sel = sels[i];
            tick();
            total++;
            if (out !== exps[i]) begin
                bad++; $display("FAIL sweep_op%0d got=%0d exp=%0d", i, out, exps[i]);
            end
        end
        total++; if (final1 !== 8'd87 || final2 !== 8'd26) begin
            bad++; $display("FAIL sweep_persist got=%0d/%0d exp=87/26", final1, final2);
        end
    endtask

    task automatic test_reset_reload();
        #2;
        rst = 1'b1;
        #1;
        total++; if (out !== 8'd0) begin bad++; $display("FAIL midrst_out got=%0d exp=0", out); end
        total++; if (final1 !== 8'd0 || final2 !== 8'd0) begin
            bad++; $display("FAIL midrst_finals got=%0d/%0d exp=0/0", final1, final2);
        end
        total++; if (currState !== 2'b00) begin bad++; $display("FAIL midrst_state got=%b exp=00", currState); end
        total++; if (nextState !== 2'b01) begin bad++; $display("FAIL midrst_next got=%b exp=01", nextState); end
        tick();
        rst = 1'b0;
        in_sel = 3'b010; num1 = 8'd2; num2 = 8'd4; out_sel = S_ADD;
        tick();
        total++; if (currState !== 2'b01) begin bad++; $display("FAIL reload_state1 got=%b exp=01", currState); end
        total++; if (final1 !== 8'd2 || final2 !== 8'd4) begin
            bad++; $display("FAIL reload_finals got=%0d/%0d exp=2/4", final1, final2);
        end
        tick();
        total++; if (currState !== 2'b10) begin bad++; $display("FAIL reload_state2 got=%b exp=10", currState); end
        tick();
        total++; if (out !== 8'd6) begin bad++; $display("FAIL reload_add got=%0d exp=6", out); end
        tick();
        total++; if (out !== 8'd6) begin bad++; $display("FAIL reload_hold got=%0d exp=6", out); end
    endtask

    task automatic test_error();
        in_sel = 3'b010; num1 = 8'd9; num2 = 8'd0; out_sel = S_ADD;
        tick();
        total++; if (out !== 8'd6) begin bad++; $display("FAIL sameedge_out got=%0d exp=6", out); end
        total++; if (final1 !== 8'd9 || final2 !== 8'd0) begin
            bad++; $display("FAIL sameedge_finals got=%0d/%0d exp=9/0", final1, final2);
        end
        out_sel = S_DIV; in_sel = 3'b100;
        #1;
        total++; if (nextState !== 2'b11) begin bad++; $display("FAIL divzero_next got=%b exp=11", nextState); end
        tick();
        total++; if (currState !== 2'b11) begin bad++; $display("FAIL divzero_state got=%b exp=11", currState); end
        total++; if (out !== 8'd6) begin bad++; $display("FAIL divzero_out got=%0d exp=6", out); end
        out_sel = S_ADD;
        tick();
        total++; if (currState !== 2'b11) begin bad++; $display("FAIL error_hold got=%b exp=11", currState); end
        total++; if (out !== 8'd6) begin bad++; $display("FAIL error_out_hold got=%0d exp=6", out); end
        on = 1'b0; in_sel = 3'b010; num1 = 8'h11; num2 = 8'h22;
        #1;
        total++; if (nextState !== 2'b00) begin bad++; $display("FAIL off_next got=%b exp=00", nextState); end
        tick();
        total++; if (currState !== 2'b00) begin bad++; $display("FAIL off_state got=%b exp=00", currState); end
        total++; if (final1 !== 8'd9 || final2 !== 8'd0) begin
            bad++; $display("FAIL off_freeze got=%0d/%0d exp=9/0", final1, final2);
        end
    endtask

    task automatic test_operand_ctrl();
        on = 1'b1; in_sel = 3'b010; num1 = 8'h33; num2 = 8'h44; out_sel = S_OR;
        tick();
        total++; if (final1 !== 8'h33 || final2 !== 8'h44) begin
            bad++; $display("FAIL ctrl_load got=%h/%h exp=33/44", final1, final2);
        end
        in_sel = 3'b100; num1 = 8'hAA; num2 = 8'hBB;
        tick();
        total++; if (final1 !== 8'h33 || final2 !== 8'h44) begin
            bad++; $display("FAIL ctrl_persist got=%h/%h exp=33/44", final1, final2);
        end
        in_sel = 3'b000;
        tick();
        total++; if (out !== 8'h77) begin bad++; $display("FAIL ctrl_or got=%h exp=77", out); end
        total++; if (final1 !== 8'h33 || final2 !== 8'h44) begin
            bad++; $display("FAIL ctrl_none_hold got=%h/%h exp=33/44", final1, final2);
        end
        in_sel = 3'b011;
        tick();
        total++; if (final1 !== 8'h00 || final2 !== 8'h00) begin
            bad++; $display("FAIL ctrl_clear_prio got=%h/%h exp=00/00", final1, final2);
        end
        in_sel = 3'b110; num1 = 8'h0F; num2 = 8'h3C;
        tick();
        total++; if (final1 !== 8'h0F || final2 !== 8'h3C) begin
            bad++; $display("FAIL ctrl_load_prio got=%h/%h exp=0f/3c", final1, final2);
        end
        in_sel = 3'b100; out_sel = 7'b0000011;
        #1;
        total++; if (nextState !== 2'b11) begin bad++; $display("FAIL badsel_next got=%b exp=11", nextState); end
        tick();
        total++; if (currState !== 2'b11) begin bad++; $display("FAIL badsel_state got=%b exp=11", currState); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL badsel_out got=%h exp=00", out); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_bringup_add();
        test_op_sweep();
        test_reset_reload();
        test_error();
        test_operand_ctrl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
